// File: rtl/switch_cond_pkg.sv
// Shared types and defaults for the a/s/d switch conditioner.
// Channel indices map switch bits onto the logic block inputs.
package switch_cond_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_COUNT
  } db_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  localparam int CH_A = 2;
  localparam int CH_S = 1;
  localparam int CH_D = 0;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_ch.sv
// One switch channel: synchronizer chain, qualification counter,
// debounce FSM and registered clean/rise/fall outputs.
module debounce_ch
  import switch_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // sync is the only view of raw_i the rest of the channel may use
  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync != clean_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_COUNT: begin
        if (sync == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          clean_d = sync;
          rise_d  = sync;
          fall_d  = ~sync;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions raw board switches into clean a/s/d levels plus
// per-channel edge pulses; one independent debouncer per channel.
module switch_conditioner
  import switch_cond_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_raw[i]),
      .clean_o(sw_clean[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

endmodule
